// File: rtl/md_seq_if.sv
// md_seq_if: issue/result bundle between decode (master) and the multiply/divide sequencer (slave).
// Latency: none, wires only.
// Backpressure: stall travels from the sequencer back to decode.
// Signals:
//   start, op, a, b  : issue strobe, 0=MULTU / 1=DIVU, unsigned rs/rt operands
//   rd_hilo          : decode holds MFHI/MFLO this cycle
//   busy, stall, done: run status, decode hold request, one-cycle completion pulse
//   hi, lo           : architectural HI/LO registers
interface md_seq_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hilo;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, rd_hilo,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, rd_hilo,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/md_seq.sv
// md_seq: iterative MULTU (shift-add) / DIVU (restoring) unit that owns the HI/LO registers.
// Latency: 32 iterations; done is high 33 cycles after the cycle in which start is presented.
// Backpressure: while running, stall = start | rd_hilo, and a start presented in that window is dropped.
// Ports: clk, rst_n (async, active low); bus (md_seq_if.slave) carries start/op/a/b/rd_hilo in and
//        busy/stall/done/hi/lo out.
// Build option: define MD_SEQ_DIVU_EN to include the divider. Without it, DIVU issues are ignored.
module md_seq (
  input  logic     clk,
  input  logic     rst_n,
  md_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  // Work registers are kept apart from hi/lo, so an aborted operation leaves HI/LO intact.
  // MULTU: work_hi = upper partial product, work_lo = multiplier, which is shifted out as
  //        product bits are shifted in.
  // DIVU:  work_hi = partial remainder, work_lo = dividend, which is shifted out as quotient
  //        bits are shifted in.
  logic [31:0] work_hi;
  logic [31:0] work_lo;
  logic [31:0] opnd_b;
  logic [31:0] work_hi_nxt;
  logic [31:0] work_lo_nxt;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        accept;
  logic        last_iter;

  // Multiply step: add the multiplicand when the current multiplier bit is set, then shift
  // the whole 65-bit {carry, upper, multiplier} right by one.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opnd_b : 32'd0)};

`ifdef MD_SEQ_DIVU_EN
  logic        op_div;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;

  // Only a start in IDLE or DONE is taken. A start in RUN is dropped, and decode re-presents it.
  assign accept    = (state != RUN) & bus.start;

  // Restoring step: shift the next dividend bit into the remainder, then subtract the divisor
  // if it fits. The remainder always stays below the divisor, or below 2^32 when b == 0, so
  // the 32-bit difference is exact. With b == 0 every step subtracts, which gives an all-ones
  // quotient and remainder == a.
  assign div_shift = {work_hi, work_lo[31]};
  assign div_ge    = div_shift >= {1'b0, opnd_b};
  assign div_rem   = div_shift[31:0] - opnd_b;
`else
  // Without the divider, a DIVU issue never leaves IDLE/DONE.
  assign accept    = (state != RUN) & bus.start & ~bus.op;
`endif

  assign last_iter = (cnt == 6'd31);

  always_comb begin
    work_hi_nxt = mul_sum[32:1];
    work_lo_nxt = {mul_sum[0], work_lo[31:1]};
`ifdef MD_SEQ_DIVU_EN
    if (op_div) begin
      work_hi_nxt = div_ge ? div_rem : div_shift[31:0];
      work_lo_nxt = {work_lo[30:0], div_ge};
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      work_hi <= 32'd0;
      work_lo <= 32'd0;
      opnd_b  <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
`ifdef MD_SEQ_DIVU_EN
      op_div  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= 6'd0;
        work_hi <= 32'd0;
        work_lo <= bus.a;
        opnd_b  <= bus.b;
`ifdef MD_SEQ_DIVU_EN
        op_div  <= bus.op;
`endif
      end else if (state == RUN) begin
        cnt     <= cnt + 6'd1;
        work_hi <= work_hi_nxt;
        work_lo <= work_lo_nxt;
        // HI/LO commit only on the final iteration, which is the RUN->DONE edge.
        if (last_iter) begin
          hi_r <= work_hi_nxt;
          lo_r <= work_lo_nxt;
        end
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.stall = (state == RUN) & (bus.start | bus.rd_hilo);
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: scoreboard bench for md_seq. The driver pushes the expected {hi,lo} and the
// expected done cycle for every accepted issue. A negedge monitor pops one entry on every
// done pulse and checks that hi/lo hold their committed values throughout RUN.
module tb_md_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_seq_if bus();
  md_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

`ifdef MD_SEQ_DIVU_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] res;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'd0;
  logic [31:0] arch_hi = 32'd0;
  logic [31:0] arch_lo = 32'd0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Reference: the architectural meaning of MULTU/DIVU, including the b==0 convention.
  function automatic logic [63:0] model(input bit o, input logic [31:0] x, input logic [31:0] y);
    if (!o) return {32'd0, x} * {32'd0, y};
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    return {x % y, x / y};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_hilo", {bus.hi, bus.lo}, mon_e.res);
        check("done_cycle", {32'd0, cyc}, {32'd0, mon_e.cyc});
        arch_hi = mon_e.res[63:32];
        arch_lo = mon_e.res[31:0];
      end
    end else if (rst_n && bus.busy) begin
      check("hilo_hold", {bus.hi, bus.lo}, {arch_hi, arch_lo});
    end
  end

  // Called at a negedge; returns one negedge later with start low again.
  task automatic issue(input bit o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    bit   taken;
    taken   = !o || DIV_EN;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    if (taken) begin
      e.res = model(o, x, y);
      e.cyc = cyc + 32'd33;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_issue", {63'd0, bus.busy}, {63'd0, taken});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wait_idle: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {63'd0, bus.done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          o;
    logic [31:0] x;
    logic [31:0] y;
    bus.start   = 1'b0;
    bus.op      = 1'b0;
    bus.a       = 32'd0;
    bus.b       = 32'd0;
    bus.rd_hilo = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_ctl", {61'd0, bus.busy, bus.stall, bus.done}, 64'd0);
    rst_n = 1'b1;

    // Full-width product.
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    check("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

`ifdef MD_SEQ_DIVU_EN
    issue(1'b1, 32'd100, 32'd7);
    wait_idle();
    check("divu_100_7", {bus.hi, bus.lo}, {32'd2, 32'd14});
    issue(1'b1, 32'h1234_5678, 32'd0);
    wait_idle();
    check("divu_by_zero", {bus.hi, bus.lo}, {32'h1234_5678, 32'hFFFF_FFFF});
`else
    issue(1'b1, 32'd10, 32'd2);
    repeat (4) begin
      check("nodiv_busy", {63'd0, bus.busy}, 64'd0);
      check("nodiv_hilo", {bus.hi, bus.lo}, {arch_hi, arch_lo});
      @(negedge clk);
    end
    issue(1'b0, 32'd10, 32'd2);
    wait_idle();
    check("nodiv_multu", {bus.hi, bus.lo}, 64'd20);
`endif

    // MFHI/MFLO during RUN stalls and still sees the old HI/LO.
    issue(1'b0, 32'd3, 32'd5);
    repeat (8) @(negedge clk);
    bus.rd_hilo = 1'b1;
    #1;
    check("stall_rd_hilo_run", {63'd0, bus.stall}, 64'd1);
    check("hilo_old_in_run", {bus.hi, bus.lo}, {arch_hi, arch_lo});
    wait_done();
    #1;
    check("stall_in_done", {63'd0, bus.stall}, 64'd0);
    check("hilo_new_in_done", {bus.hi, bus.lo}, 64'd15);
    bus.rd_hilo = 1'b0;
    wait_idle();

    // A start during RUN is dropped; the same start held into DONE is accepted.
    issue(1'b0, 32'd11, 32'd13);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    #1;
    check("stall_start_run", {63'd0, bus.stall}, 64'd1);
    wait_done();
    begin
      exp_t e;
      e.res = model(1'b0, 32'd9, 32'd3);
      e.cyc = cyc + 32'd33;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("restart_from_done", {63'd0, bus.busy}, 64'd1);
    wait_idle();
    check("second_result", {bus.hi, bus.lo}, 64'd27);

    // Reset in the middle of RUN aborts without committing a partial result.
    issue(1'b0, 32'd6, 32'd7);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    check("abort_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
    exp_q.delete();
    arch_hi = 32'd0;
    arch_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'd2, 32'd2);
    wait_idle();
    check("after_abort", {bus.hi, bus.lo}, 64'd4);

    // Randomised mix, including zero and small divisors.
    for (int i = 0; i < 16; i++) begin
      o = 1'($urandom_range(0, 1));
      x = (i % 7 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      y = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom);
      issue(o, x, y);
      wait_idle();
    end

    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  in  1  MULTU/DIVU issue strobe from decode.
REQ-005 SHALL have port: op  in  1  operation select, 0=MULTU, 1=DIVU.
REQ-006 SHALL have ports: a, b  in  32 each  rs, rt operands, unsigned.
REQ-007 SHALL have port: rd_hilo  in  1  MFHI/MFLO in decode this cycle.
REQ-008 SHALL have port: busy  out  1  operation in progress.
REQ-009 SHALL have port: stall  out  1  hold PC/decode this cycle.
REQ-010 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE, with a 6-bit iteration counter cnt.
REQ-013 IDLE or DONE with start=1 SHALL latch a, b and op, clear the partial product/remainder, set cnt=0, and enter RUN.
REQ-014 RUN SHALL perform one iteration per cycle: shift-add for MULTU, restoring shift-subtract for DIVU.
REQ-015 RUN SHALL leave RUN for DONE on the edge where cnt==31, i.e. after exactly 32 iterations.
REQ-016 MULTU result SHALL be hi:lo = full 64-bit product a*b, with no truncation.
REQ-017 DIVU result SHALL be lo = a/b (quotient) and hi = a%b (remainder).
REQ-018 DIVU with b==0 SHALL NOT be trapped or shortened; it SHALL give lo=32'hFFFF_FFFF and hi=a.
REQ-019 hi/lo SHALL hold their previous values throughout RUN and SHALL update only on the RUN->DONE edge.
REQ-020 done SHALL be 1 only in DONE, so done rises 33 cycles after the start edge.
REQ-021 busy SHALL be 1 exactly in RUN.
REQ-022 stall SHALL be combinational: busy & (start | rd_hilo).
REQ-023 stall SHALL be 0 in IDLE and DONE; MFHI in DONE reads the new values.
REQ-024 start while busy SHALL be ignored (no operand reload, no restart); the CPU re-presents it because stall=1.
REQ-025 start in DONE SHALL be accepted: done pulses in that same cycle and RUN restarts on the next edge.
REQ-026 Internal work registers SHALL be distinct from hi/lo so that an abort never corrupts HI/LO.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, cnt=0, hi=0, lo=0, busy=0, stall=0, done=0, and clear all work registers.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no partial result is written.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-030 Macro MD_SEQ_DIVU_EN SHALL control the divider.
REQ-031 With MD_SEQ_DIVU_EN defined, DIVU SHALL behave per REQ-017/018.
REQ-032 Without MD_SEQ_DIVU_EN, the divide datapath SHALL be absent, start with op=1 SHALL be ignored (state stays IDLE/DONE, hi/lo unchanged, done not pulsed), and MULTU SHALL be unaffected.

Verification
REQ-033 MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> done at start+33, hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-034 DIVU a=100, b=7 -> lo=14, hi=2; DIVU a=32'h1234_5678, b=0 -> lo=32'hFFFF_FFFF, hi=32'h1234_5678.
REQ-035 MULTU 3*5 issued, rd_hilo=1 at cycle 10 -> stall=1 and hi/lo still old; at DONE: stall=0, lo=15, hi=0.
REQ-036 Second start at cycle 5 of RUN with a=9 -> ignored, stall=1, result reflects the first operands; the same start re-presented in DONE is accepted.
REQ-037 rst_n pulsed low at cycle 20 of MULTU 6*7 -> immediately hi=lo=0, busy=0, done never pulses; a new MULTU 2*2 then gives lo=4.
REQ-038 Build without MD_SEQ_DIVU_EN: DIVU 10/2 -> busy stays 0, hi/lo unchanged, no done pulse; MULTU 10*2 -> lo=20.
